// File: rtl/decode_stage_hs.sv
// ID stage of the RISC-V-lite pipeline: register file, immediate decode,
// write-to-read bypass, load-use bubble insertion and a valid/ready ID/EX register.
module decode_stage_hs #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int CW_W     = 13,
    parameter int ALUOP_W  = 4,
    parameter int LOAD_BIT = 2,
    parameter int BYPASS   = 1,
    parameter int STALL_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic [31:0]              ir_in,
    input  logic [XLEN-1:0]          pc_in,
    input  logic [XLEN-1:0]          npc_in,
    input  logic                     rd1_en,
    input  logic                     rd2_en,
    input  logic [CW_W-1:0]          cw_in,
    input  logic [ALUOP_W-1:0]       aluop_in,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_addr,
    input  logic [XLEN-1:0]          wb_data,
    output logic                     ex_valid,
    input  logic                     ex_ready,
    output logic [XLEN-1:0]          r1,
    output logic [XLEN-1:0]          r2,
    output logic [XLEN-1:0]          imm_out,
    output logic [XLEN-1:0]          pc_out,
    output logic [XLEN-1:0]          npc_out,
    output logic [$clog2(NREGS)-1:0] rd_exe,
    output logic [CW_W-1:0]          cw_exe,
    output logic [ALUOP_W-1:0]       aluop_exe,
    output logic [STALL_W-1:0]       stall_cnt
);

    localparam int          AW = $clog2(NREGS);
    localparam int unsigned NR = 1 << AW;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [XLEN-1:0] rf [NR];

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rf1;
    logic [XLEN-1:0] rf2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            byp1;
    logic            byp2;
    logic            haz;
    logic            adv;

    assign rs1 = ir_in[15 +: AW];
    assign rs2 = ir_in[20 +: AW];
    assign rd  = ir_in[7 +: AW];

    always_comb begin
        imm32 = '0;
        case (ir_in[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{ir_in[31]}}, ir_in[31:20]};
            OP_STORE:                 imm32 = {{20{ir_in[31]}}, ir_in[31:25], ir_in[11:7]};
            OP_BRANCH:                imm32 = {{19{ir_in[31]}}, ir_in[31], ir_in[7],
                                               ir_in[30:25], ir_in[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm32 = {ir_in[31:12], 12'b0};
            OP_JAL:                   imm32 = {{11{ir_in[31]}}, ir_in[31], ir_in[19:12],
                                               ir_in[20], ir_in[30:21], 1'b0};
            default:                  imm32 = '0;
        endcase
        imm = XLEN'($signed(imm32));
    end

    // A same-cycle WB write to the register being read wins over the stale RF entry.
    always_comb begin
        rf1  = (rs1 == '0) ? '0 : rf[rs1];
        rf2  = (rs2 == '0) ? '0 : rf[rs2];
        byp1 = (BYPASS != 0) && wb_en && (wb_addr == rs1) && (rs1 != '0);
        byp2 = (BYPASS != 0) && wb_en && (wb_addr == rs2) && (rs2 != '0);
        op1  = !rd1_en ? '0 : (byp1 ? wb_data : rf1);
        op2  = !rd2_en ? '0 : (byp2 ? wb_data : rf2);
    end

    assign haz = ex_valid && cw_exe[LOAD_BIT] && (rd_exe != '0) &&
                 ((rd1_en && (rs1 == rd_exe)) || (rd2_en && (rs2 == rd_exe)));
    assign adv      = !ex_valid || ex_ready;
    assign id_ready = flush || (adv && !haz);

    always_ff @(posedge clk) begin
        if (rst) begin
            rf <= '{default: '0};
        end else if (wb_en && (wb_addr != '0)) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            r1        <= '0;
            r2        <= '0;
            imm_out   <= '0;
            pc_out    <= '0;
            npc_out   <= '0;
            rd_exe    <= '0;
            cw_exe    <= '0;
            aluop_exe <= '0;
        end else if (flush) begin
            ex_valid  <= 1'b0;
            cw_exe    <= '0;
            aluop_exe <= '0;
        end else if (adv) begin
            if (id_valid && !haz) begin
                ex_valid  <= 1'b1;
                r1        <= op1;
                r2        <= op2;
                imm_out   <= imm;
                pc_out    <= pc_in;
                npc_out   <= npc_in;
                rd_exe    <= rd;
                cw_exe    <= cw_in;
                aluop_exe <= aluop_in;
            end else begin
                // Bubble: only the control fields are cleared, operands keep their old values.
                ex_valid  <= 1'b0;
                cw_exe    <= '0;
                aluop_exe <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (id_valid && adv && haz && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage_hs.sv
// Scoreboard bench for decode_stage_hs: default instance plus a BYPASS=0, STALL_W=2 instance
// driven by the same stimulus.
module tb_decode_stage_hs;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic [31:0] ir_in;
    logic [31:0] pc_in;
    logic [31:0] npc_in;
    logic        rd1_en;
    logic        rd2_en;
    logic [12:0] cw_in;
    logic [3:0]  aluop_in;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_ready;

    logic        id_ready,  nb_id_ready;
    logic        ex_valid,  nb_ex_valid;
    logic [31:0] r1,        nb_r1;
    logic [31:0] r2,        nb_r2;
    logic [31:0] imm_out,   nb_imm_out;
    logic [31:0] pc_out,    nb_pc_out;
    logic [31:0] npc_out,   nb_npc_out;
    logic [4:0]  rd_exe,    nb_rd_exe;
    logic [12:0] cw_exe,    nb_cw_exe;
    logic [3:0]  aluop_exe, nb_aluop_exe;
    logic [15:0] stall_cnt;
    logic [1:0]  nb_stall_cnt;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [4:0]  rd;
        logic [12:0] cw;
        logic [3:0]  aluop;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks;
    int   errors;

    decode_stage_hs dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .ir_in(ir_in), .pc_in(pc_in), .npc_in(npc_in), .rd1_en(rd1_en), .rd2_en(rd2_en),
        .cw_in(cw_in), .aluop_in(aluop_in), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready), .r1(r1), .r2(r2),
        .imm_out(imm_out), .pc_out(pc_out), .npc_out(npc_out), .rd_exe(rd_exe),
        .cw_exe(cw_exe), .aluop_exe(aluop_exe), .stall_cnt(stall_cnt)
    );

    decode_stage_hs #(.BYPASS(0), .STALL_W(2)) dut_nb (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(nb_id_ready),
        .ir_in(ir_in), .pc_in(pc_in), .npc_in(npc_in), .rd1_en(rd1_en), .rd2_en(rd2_en),
        .cw_in(cw_in), .aluop_in(aluop_in), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_valid(nb_ex_valid), .ex_ready(ex_ready), .r1(nb_r1),
        .r2(nb_r2), .imm_out(nb_imm_out), .pc_out(nb_pc_out), .npc_out(nb_npc_out),
        .rd_exe(nb_rd_exe), .cw_exe(nb_cw_exe), .aluop_exe(nb_aluop_exe),
        .stall_cnt(nb_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // EX consumes the ID/EX contents on the coming edge: compare against the oldest expectation.
    always @(negedge clk) begin
        if (ex_valid === 1'b1 && ex_ready === 1'b1 && flush === 1'b0 && rst === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: ex_valid=1 with no expected entry (pc_out=%h)", pc_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (r1 !== mon_e.r1) begin errors++;
                    $display("FAIL sb_r1 pc=%h: got %h want %h", mon_e.pc, r1, mon_e.r1); end
                checks++;
                if (r2 !== mon_e.r2) begin errors++;
                    $display("FAIL sb_r2 pc=%h: got %h want %h", mon_e.pc, r2, mon_e.r2); end
                checks++;
                if (imm_out !== mon_e.imm) begin errors++;
                    $display("FAIL sb_imm pc=%h: got %h want %h", mon_e.pc, imm_out, mon_e.imm); end
                checks++;
                if (pc_out !== mon_e.pc) begin errors++;
                    $display("FAIL sb_pc: got %h want %h", pc_out, mon_e.pc); end
                checks++;
                if (npc_out !== mon_e.npc) begin errors++;
                    $display("FAIL sb_npc pc=%h: got %h want %h", mon_e.pc, npc_out, mon_e.npc); end
                checks++;
                if (rd_exe !== mon_e.rd) begin errors++;
                    $display("FAIL sb_rd pc=%h: got %h want %h", mon_e.pc, rd_exe, mon_e.rd); end
                checks++;
                if (cw_exe !== mon_e.cw) begin errors++;
                    $display("FAIL sb_cw pc=%h: got %h want %h", mon_e.pc, cw_exe, mon_e.cw); end
                checks++;
                if (aluop_exe !== mon_e.aluop) begin errors++;
                    $display("FAIL sb_aluop pc=%h: got %h want %h", mon_e.pc, aluop_exe, mon_e.aluop); end
            end
        end
    end

    // Drive one instruction and wait (bounded) until the stage accepts it.
    task automatic send(input logic [31:0] ir, input logic [31:0] pc, input logic e1,
                        input logic e2, input logic [12:0] cw, input logic [3:0] aluop,
                        input logic [31:0] er1, input logic [31:0] er2,
                        input logic [31:0] eimm, output int stalls);
        exp_t e;
        bit   acc;
        ir_in    = ir;
        pc_in    = pc;
        npc_in   = pc + 32'd4;
        rd1_en   = e1;
        rd2_en   = e2;
        cw_in    = cw;
        aluop_in = aluop;
        id_valid = 1'b1;
        e.r1 = er1; e.r2 = er2; e.imm = eimm; e.pc = pc; e.npc = pc + 32'd4;
        e.rd = ir[11:7]; e.cw = cw; e.aluop = aluop;
        stalls = 0;
        acc = 1'b0;
        for (int k = 0; k < 16 && !acc; k++) begin
            @(negedge clk);
            if (id_ready === 1'b1) begin
                exp_q.push_back(e);
                acc = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        id_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_accept pc=%h: not accepted within 16 cycles", pc);
        end
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid: got %b want 0", ex_valid); end
        checks++;
        if ({r1, r2, imm_out, pc_out, npc_out} !== '0) begin errors++;
            $display("FAIL rst_data: r1=%h r2=%h imm=%h pc=%h npc=%h want all 0",
                     r1, r2, imm_out, pc_out, npc_out); end
        checks++;
        if ({rd_exe, cw_exe, aluop_exe} !== '0) begin errors++;
            $display("FAIL rst_ctrl: rd=%h cw=%h aluop=%h want 0", rd_exe, cw_exe, aluop_exe); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL rst_id_ready: got %b want 1", id_ready); end
    endtask

    task automatic test_rf_init();
        int st;
        wb_write(5'd5, 32'h0000_1234);
        wb_write(5'd0, 32'h0000_FFFF);
        wb_write(5'd2, 32'h0000_0022);
        wb_write(5'd3, 32'h0000_0033);
        wb_write(5'd7, 32'h0000_0BAD);
        // add x1, x5, x0
        send(32'h0002_80B3, 32'h100, 1'b1, 1'b1, 13'h0A1, 4'h1,
             32'h0000_1234, 32'h0, 32'h0, st);
        checks++;
        if (ex_valid !== 1'b1) begin errors++; $display("FAIL init_latency: ex_valid=%b want 1", ex_valid); end
    endtask

    task automatic test_back_to_back_imm();
        int st;
        send(32'hFFF0_0113, 32'h104, 1'b1, 1'b0, 13'h0A1, 4'h2, 32'h0, 32'h0, 32'hFFFF_FFFF, st);
        send(32'h7E50_2E23, 32'h108, 1'b1, 1'b1, 13'h1F3, 4'h3, 32'h0, 32'h0000_1234, 32'h0000_07FC, st);
        send(32'hFE00_0EE3, 32'h10C, 1'b1, 1'b1, 13'h010, 4'h4, 32'h0, 32'h0, 32'hFFFF_FFFC, st);
        send(32'hABCD_E337, 32'h110, 1'b0, 1'b0, 13'h020, 4'h5, 32'h0, 32'h0, 32'hABCD_E000, st);
        send(32'h0010_00EF, 32'h114, 1'b0, 1'b0, 13'h040, 4'h6, 32'h0, 32'h0, 32'h0000_0800, st);
        checks++;
        if (st !== 0) begin errors++; $display("FAIL b2b_stalls: got %0d want 0", st); end
    endtask

    task automatic test_bypass();
        int st;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_CAFE;
        // addi x8, x7, 0 decoded while WB writes x7
        send(32'h0003_8413, 32'h118, 1'b1, 1'b0, 13'h0A1, 4'h1, 32'h0000_CAFE, 32'h0, 32'h0, st);
        wb_en = 1'b0;
        checks++;
        if (nb_r1 !== 32'h0000_0BAD) begin errors++;
            $display("FAIL nobypass_r1: got %h want %h", nb_r1, 32'h0000_0BAD); end
        // addi x9, x7, 0 afterwards sees the committed value in both variants
        send(32'h0003_8493, 32'h11C, 1'b1, 1'b0, 13'h0A1, 4'h1, 32'h0000_CAFE, 32'h0, 32'h0, st);
        checks++;
        if (nb_r1 !== 32'h0000_CAFE) begin errors++;
            $display("FAIL nobypass_rf_updated: got %h want %h", nb_r1, 32'h0000_CAFE); end
    endtask

    task automatic test_load_use();
        int   st;
        exp_t e;
        send(32'h0001_2183, 32'h120, 1'b1, 1'b0, 13'h004, 4'h7, 32'h0000_0022, 32'h0, 32'h0, st);
        ir_in = 32'h0021_8233; pc_in = 32'h124; npc_in = 32'h128;
        rd1_en = 1'b1; rd2_en = 1'b1; cw_in = 13'h0A1; aluop_in = 4'h1; id_valid = 1'b1;
        #1;
        checks++;
        if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_id_ready: got %b want 0", id_ready); end
        @(posedge clk); #1;
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble_valid: got %b want 0", ex_valid); end
        checks++;
        if ({cw_exe, aluop_exe} !== '0) begin errors++;
            $display("FAIL lu_bubble_ctrl: cw=%h aluop=%h want 0", cw_exe, aluop_exe); end
        checks++;
        if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_release: id_ready=%b want 1", id_ready); end
        e.r1 = 32'h0000_0033; e.r2 = 32'h0000_0022; e.imm = 32'h0; e.pc = 32'h124;
        e.npc = 32'h128; e.rd = 5'd4; e.cw = 13'h0A1; e.aluop = 4'h1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        id_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b1) begin errors++; $display("FAIL lu_add_enters: ex_valid=%b want 1", ex_valid); end
    endtask

    task automatic test_backpressure_flush();
        int st;
        send(32'hABCD_E337, 32'h200, 1'b0, 1'b0, 13'h020, 4'h5, 32'h0, 32'h0, 32'hABCD_E000, st);
        ex_ready = 1'b0;
        ir_in = 32'h0003_8493; pc_in = 32'h204; npc_in = 32'h208;
        rd1_en = 1'b1; rd2_en = 1'b0; cw_in = 13'h0A1; aluop_in = 4'h1; id_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (id_ready !== 1'b0) begin errors++;
                $display("FAIL bp_id_ready cycle %0d: got %b want 0", k, id_ready); end
            @(posedge clk); #1;
            checks++;
            if ({ex_valid, imm_out, pc_out, cw_exe, aluop_exe} !==
                {1'b1, 32'hABCD_E000, 32'h200, 13'h020, 4'h5}) begin errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b imm=%h pc=%h cw=%h aluop=%h",
                         k, ex_valid, imm_out, pc_out, cw_exe, aluop_exe); end
        end
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_id_ready: got %b want 1", id_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        id_valid = 1'b0;
        checks++;
        if ({ex_valid, cw_exe, aluop_exe} !== '0) begin errors++;
            $display("FAIL flush_kill: valid=%b cw=%h aluop=%h want 0", ex_valid, cw_exe, aluop_exe); end
        checks++;
        if (exp_q.size() != 1) begin errors++;
            $display("FAIL flush_queue: %0d entries want 1", exp_q.size()); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        ex_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ex_valid !== 1'b0) begin errors++;
            $display("FAIL flush_discard: ex_valid=%b want 0", ex_valid); end
    endtask

    task automatic test_saturation();
        int st;
        for (int p = 0; p < 4; p++) begin
            send(32'h0001_2183, 32'h300 + 32'(p * 8), 1'b1, 1'b0, 13'h004, 4'h7,
                 32'h0000_0022, 32'h0, 32'h0, st);
            send(32'h0021_8233, 32'h304 + 32'(p * 8), 1'b1, 1'b1, 13'h0A1, 4'h1,
                 32'h0000_0033, 32'h0000_0022, 32'h0, st);
            checks++;
            if (st !== 1) begin errors++; $display("FAIL sat_bubbles pair %0d: got %0d want 1", p, st); end
        end
        checks++;
        if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt16: got %0d want 5", stall_cnt); end
        checks++;
        if (nb_stall_cnt !== 2'd3) begin errors++; $display("FAIL stall_cnt2_sat: got %0d want 3", nb_stall_cnt); end
    endtask

    task automatic test_mid_reset();
        int st;
        send(32'h0010_00EF, 32'h400, 1'b0, 1'b0, 13'h040, 4'h6, 32'h0, 32'h0, 32'h0000_0800, st);
        rst = 1'b1;
        id_valid = 1'b1;
        checks++;
        if (ex_valid !== 1'b1) begin errors++; $display("FAIL mr_pre_valid: got %b want 1", ex_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        id_valid = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        checks++;
        if ({ex_valid, r1, r2, imm_out, pc_out, npc_out, rd_exe, cw_exe, aluop_exe} !== '0) begin errors++;
            $display("FAIL mr_outputs: valid=%b r1=%h r2=%h imm=%h pc=%h npc=%h rd=%h cw=%h aluop=%h",
                     ex_valid, r1, r2, imm_out, pc_out, npc_out, rd_exe, cw_exe, aluop_exe); end
        checks++;
        if ({stall_cnt, nb_stall_cnt} !== '0) begin errors++;
            $display("FAIL mr_stall: got %0d / %0d want 0", stall_cnt, nb_stall_cnt); end
        checks++;
        if (id_ready !== 1'b1) begin errors++; $display("FAIL mr_id_ready: got %b want 1", id_ready); end
        // x5 was cleared by the reset
        send(32'h0002_80B3, 32'h404, 1'b1, 1'b1, 13'h0A1, 4'h1, 32'h0, 32'h0, 32'h0, st);
        checks++;
        if (nb_r1 !== 32'h0) begin errors++; $display("FAIL mr_rf_cleared: got %h want 0", nb_r1); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin errors++;
            $display("FAIL sb_leftover: %0d entries never produced", exp_q.size()); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ir_in = '0; pc_in = '0; npc_in = '0;
        rd1_en = 1'b0; rd2_en = 1'b0; cw_in = '0; aluop_in = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
        test_reset();
        test_rf_init();
        test_back_to_back_imm();
        test_bypass();
        test_load_use();
        test_backpressure_flush();
        test_saturation();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage_hs.md
Name: decode_stage_hs

Overview:
Parametrised successor of the ID stage for the RISC-V-lite pipeline. It holds the integer register file and decodes rs1/rs2/rd and the sign-extended immediate for the I/S/B/U/J formats. It owns the ID/EX pipeline register behind a valid/ready handshake, adds write-to-read bypass, detects load-use hazards and inserts bubbles, and counts stall cycles. It sits between the fetch/ID boundary and the EX stage.

Parameters:
XLEN, 32, datapath width (r1, r2, imm, pc, npc, wb_data)
NREGS, 32, register count; address width AW = $clog2(NREGS); register 0 hard-wired to zero
CW_W, 13, width of the control word forwarded to EX
ALUOP_W, 4, width of the ALU opcode forwarded to EX
LOAD_BIT, 2, index in cw_exe that marks a load (memory-read) instruction
BYPASS, 1, 1 = same-cycle WB data forwarded to ID reads; 0 = RF read returns old value
STALL_W, 16, stall counter width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  kill the ID/EX contents and the incoming instruction (branch taken)
id_valid  in  1  ir_in/pc_in/npc_in/cw_in/aluop_in hold a valid instruction
id_ready  out  1  stage accepts the ID instruction this cycle
ir_in  in  32  instruction word
pc_in  in  XLEN  instruction PC
npc_in  in  XLEN  PC+4
rd1_en  in  1  instruction reads rs1
rd2_en  in  1  instruction reads rs2
cw_in  in  CW_W  control word for EX/MEM/WB
aluop_in  in  ALUOP_W  ALU opcode
wb_en  in  1  register-file write enable from WB
wb_addr  in  AW  write address
wb_data  in  XLEN  write data
ex_valid  out  1  ID/EX register holds a valid instruction
ex_ready  in  1  EX consumes the ID/EX contents this cycle
r1, r2  out  XLEN  registered operands
imm_out  out  XLEN  registered sign-extended immediate
pc_out, npc_out  out  XLEN  registered PC and next PC
rd_exe  out  AW  registered destination address
cw_exe  out  CW_W  registered control word; zero when ex_valid=0
aluop_exe  out  ALUOP_W  registered ALU opcode; zero when ex_valid=0
stall_cnt  out  STALL_W  saturating count of load-use stall cycles

Behaviour:
- Reset (rst=1 at an edge): all outputs and all RF entries go to 0; id_ready comb = 1 after reset.
- Decode (combinational): rs1=ir[19:15], rs2=ir[24:20], rd=ir[11:7], each truncated to AW bits. Immediate selected by opcode ir[6:0]:
  - I (0000011, 0010011, 1100111): ir[31:20]
  - S (0100011): {ir[31:25], ir[11:7]}
  - B (1100011): {ir[31], ir[7], ir[30:25], ir[11:8], 0}
  - U (0110111, 0010111): {ir[31:12], 12'b0}
  - J (1101111): {ir[31], ir[19:12], ir[20], ir[30:21], 0}
  - any other opcode: 0
  - All formats sign-extend from ir[31] to XLEN.
- RF: write on the edge when wb_en=1 and wb_addr!=0; writes to register 0 are dropped. Reading register 0 returns 0.
- Read path: operand = 0 if its rdX_en=0. If BYPASS=1, wb_en=1 and wb_addr==rsX!=0, the operand is wb_data. Otherwise the operand is the RF content.
- Hazard (comb): haz = ex_valid & cw_exe[LOAD_BIT] & rd_exe!=0 & ((rd1_en & rs1==rd_exe) | (rd2_en & rs2==rd_exe)).
- adv = !ex_valid | ex_ready.
- id_ready = flush | (adv & !haz).
- Priority per edge: rst > flush > adv > hold.
  - flush: ex_valid<=0, cw_exe<=0, aluop_exe<=0; the incoming instruction is discarded.
  - adv & id_valid & !haz: load all ID/EX registers; ex_valid<=1.
  - adv otherwise (bubble): ex_valid<=0, cw_exe<=0, aluop_exe<=0; data registers hold.
  - !adv: every register holds (back-pressure); id_ready=0.
- Latency: 1 cycle from ID acceptance to ex_valid.
- A load-use pair produces exactly one bubble: after it the load has left ID/EX, so haz drops.
- stall_cnt: increments when id_valid & adv & haz & !flush; saturates at all-ones; cleared only by rst.
- A WB write and a read of the same register in the same cycle follow the BYPASS rule above. The RF entry itself updates at the edge.

Test Plan:
- Reset then RF init: rst 1 cycle; WB writes x5=0x1234 and x0=0xFFFF. Decode `add x1,x5,x0` -> next cycle ex_valid=1, r1=0x1234, r2=0.
- Immediates: issue `addi` imm=-1 -> imm_out=0xFFFFFFFF. `sw` offset 0x7FC -> 0x000007FC. `beq` offset -4 -> 0xFFFFFFFC. `lui` 0xABCDE -> 0xABCDE000. `jal` offset +2048 -> 0x00000800.
- Bypass: same cycle wb_en=1, wb_addr=7, wb_data=0xCAFE while decoding a rs1=x7 read -> r1=0xCAFE with BYPASS=1; r1 = old x7 with BYPASS=0.
- Load-use: `lw x3` then `add x4,x3,x2` with ex_ready=1 -> one bubble: ex_valid=0, cw_exe=0, id_ready=0 for 1 cycle; stall_cnt 0->1; add enters on the next edge.
- Back-pressure and flush: ex_ready=0 for 3 cycles -> id_ready=0 and outputs stable. Then flush=1 with id_valid=1 -> next cycle ex_valid=0, cw_exe=0, aluop_exe=0.
- Saturation and mid-operation reset: STALL_W=2, force 5 stall cycles -> stall_cnt=3. Assert rst with ex_valid=1 -> all outputs 0 on the next edge.
